alien_path_scanner: RTL and testbench
=====================================

Name: alien_path_scanner

Overview:
- Supplies `free_direction_alien_a` / `free_direction_alien_b` to the two-alien block.
- Once per frame it snapshots both alien top-left positions, converts each to board-cell coordinates and reads the tunnel-map RAM for the four neighbouring cells.
- It then publishes, atomically, a 4-bit free-direction mask per alien.
- It sits between the tunnel-map RAM read port and the alien movement logic.

Parameters:
- `board_position_X`, 11'd32, board left edge in pixels.
- `board_position_Y`, 11'd160, board top edge in pixels.
- `BOARD_COLS`, 15, number of 32-px cell columns.
- `BOARD_ROWS`, 10, number of 32-px cell rows.

Ports:
- `clk`  in  1  system clock.
- `resetN`  in  1  reset, synchronous, active-low.
- `startOfFrame`  in  1  one-cycle frame pulse.
- `alien_top_leftX_a`  in  11  alien a X position (pixels).
- `alien_top_leftY_a`  in  11  alien a Y position.
- `alien_top_leftX_b`  in  11  alien b X position.
- `alien_top_leftY_b`  in  11  alien b Y position.
- `map_rd_addr`  out  8  tunnel-map read address = row*BOARD_COLS+col.
- `map_rd_data`  in  1  1 = tunnel (free), 0 = dirt; valid one cycle after the address.
- `free_direction_alien_a`  out  4  bit0 right, bit1 left, bit2 down, bit3 up; 1 = may move.
- `free_direction_alien_b`  out  4  same encoding, alien b.
- `scan_done`  out  1  one-cycle pulse; outputs were just updated.
- `busy`  out  1  high while a scan is in progress.

Behaviour:
- **Reset** (`resetN` low at a rising edge):
  - state = IDLE.
  - Both free masks = 4'b0000.
  - `scan_done` = 0, `busy` = 0, `map_rd_addr` = 0.
  - Reset during a scan aborts it; no partial results are published.
- **FSM states:** IDLE, ADDR, DATA.
- **Start (edge E0):** IDLE with `startOfFrame` = 1 →
  - Capture all four position inputs into snapshot registers.
  - Query index i = 0; go to ADDR.
  - `startOfFrame` is ignored outside IDLE.
- **Query order:** i = 0..7 → alien a {right, left, down, up}, then alien b {right, left, down, up}.
- **ADDR state:**
  - Drive `map_rd_addr` with the neighbour-cell address for query i, or 0 if the query is masked.
  - Go to DATA.
- **DATA state:**
  - Latch the result bit = `map_rd_data` & ~masked into a shadow mask.
  - If i = 7, go to IDLE; otherwise i++ and go to ADDR.
- **Latency:** every query takes 2 cycles regardless of masking, so the latency is fixed.
  - Shadow bit for query i is latched at edge E(2i+2).
  - At E16 both output masks are loaded from the shadow registers simultaneously and `scan_done` is registered high for exactly one cycle.
  - `busy` is high from E0 through E16 exclusive.
- **Cell arithmetic (per alien, on the snapshot):**
  - dx = X − `board_position_X` and dy = Y − `board_position_Y`, 11-bit.
  - Off-board if X < `board_position_X`, Y < `board_position_Y`, dx ≥ 32*BOARD_COLS, or dy ≥ 32*BOARD_ROWS.
  - Off-board → all four of that alien's queries are masked → mask 0000.
  - col = dx[9:5], row = dy[8:5].
  - alignedX = (dx[4:0] == 0), alignedY = (dy[4:0] == 0).
- **Alignment rules:**
  - Both aligned: query the four neighbours.
  - A neighbour outside the board (col 0 left, col BOARD_COLS−1 right, row 0 up, row BOARD_ROWS−1 down) is masked to 0.
  - alignedY only, mid-column (alien moving horizontally): result = 4'b0011 (right, left); all queries masked; the forced bits are inserted at the publish edge.
  - alignedX only (moving vertically): result = 4'b1100.
  - Neither aligned: 4'b0000.
- **Output hold:** outputs hold their previous value between publishes.
- **Input stability:** position inputs may change during a scan; only the E0 snapshot is used.

Test Plan:
- **Reset:** assert `resetN` = 0 mid-scan (at E5) → next cycle masks = 0000, `busy` = 0; no `scan_done` pulse until the next `startOfFrame`.
- **Corner and edge cells, both aligned:**
  - Map = all tunnels.
  - Alien a at (448,160): col 13, row 0.
  - Alien b at (480,448): col 14, row 9.
  - Expected: a = 4'b0111 (up blocked at row 0); b = 4'b1010 (right and down blocked at the board edge).
  - `scan_done` in the cycle after E16.
- **Interior cell, mixed map:**
  - Alien a at (192,288): col 5, row 4.
  - Map tunnels at cells (col 6, row 4) and (col 5, row 3) only.
  - Expected: a = 4'b1001.
  - `map_rd_addr` sequence for queries 0..3 = 66, 64, 80, 50.
- **Mid-cell:**
  - Alien a at (200,288) → a = 4'b0011.
  - Alien b at (192,300) → b = 4'b1100.
  - Map contents irrelevant; latency is still 16 cycles.
- **Off-board:** alien a at (16,160) and alien b at (32,480) → both masks 0000.
- **Snapshot and re-trigger:**
  - Change alien a's X input at E3 → published result still reflects the E0 value.
  - A second `startOfFrame` at E8 is ignored.
  - A `startOfFrame` one cycle after `scan_done` starts a new scan.

Source files
------------

// File: rtl/alien_path_scanner.sv
// Alien path scanner: once per frame, snapshots both alien positions,
// queries the tunnel map for each alien's four neighbours and publishes
// a free-direction mask per alien atomically.
//
// Ports:
//   clk, resetN (sync, active-low), startOfFrame (1-cycle frame pulse)
//   alien_top_leftX/Y_a/b : alien top-left pixel positions
//   map_rd_addr / map_rd_data : tunnel-map read port (data valid 1 cycle later)
//   free_direction_alien_a/b : {up, down, left, right}, 1 = may move
//   scan_done : 1-cycle pulse when masks update; busy : scan in progress
module alien_path_scanner #(
    parameter logic [10:0] board_position_X = 11'd32,
    parameter logic [10:0] board_position_Y = 11'd160,
    parameter int          BOARD_COLS       = 15,
    parameter int          BOARD_ROWS       = 10
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic [10:0] alien_top_leftX_a,
    input  logic [10:0] alien_top_leftY_a,
    input  logic [10:0] alien_top_leftX_b,
    input  logic [10:0] alien_top_leftY_b,
    output logic [7:0]  map_rd_addr,
    input  logic        map_rd_data,
    output logic [3:0]  free_direction_alien_a,
    output logic [3:0]  free_direction_alien_b,
    output logic        scan_done,
    output logic        busy
);

    localparam logic [10:0] BOARD_W  = 11'(32 * BOARD_COLS);
    localparam logic [10:0] BOARD_H  = 11'(32 * BOARD_ROWS);
    localparam logic [4:0]  LAST_COL = 5'(BOARD_COLS - 1);
    localparam logic [3:0]  LAST_ROW = 4'(BOARD_ROWS - 1);
    localparam logic [7:0]  COLS8    = 8'(BOARD_COLS);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    typedef struct packed {
        logic       off;
        logic       alignedX;
        logic       alignedY;
        logic [4:0] col;
        logic [3:0] row;
    } cell_t;

    state_t      state;
    logic [2:0]  qIdx;
    logic [7:0]  shadow;
    logic [10:0] snapXa, snapYa, snapXb, snapYb;

    cell_t       cellA, cellB, cur;
    logic [1:0]  dir;
    logic        edgeHit, masked;
    logic [7:0]  base, nbrAddr, qAddr;
    logic [7:0]  shadowNext;

    function automatic cell_t toCell(input logic [10:0] x,
                                     input logic [10:0] y);
        cell_t       c;
        logic [10:0] dx, dy;
        dx = x - board_position_X;
        dy = y - board_position_Y;
        c.off = (x < board_position_X) || (y < board_position_Y) ||
                (dx >= BOARD_W) || (dy >= BOARD_H);
        c.alignedX = (dx[4:0] == 5'd0);
        c.alignedY = (dy[4:0] == 5'd0);
        c.col = dx[9:5];
        c.row = dy[8:5];
        return c;
    endfunction

    // Mid-cell aliens skip the map: they may only continue along their
    // current axis. These bits are merged in when the masks are published.
    function automatic logic [3:0] forcedBits(input cell_t c);
        logic [3:0] f;
        f = 4'b0000;
        if (!c.off) begin
            if (c.alignedY && !c.alignedX)
                f = 4'b0011;
            else if (c.alignedX && !c.alignedY)
                f = 4'b1100;
        end
        return f;
    endfunction

    assign cellA = toCell(snapXa, snapYa);
    assign cellB = toCell(snapXb, snapYb);
    assign cur   = qIdx[2] ? cellB : cellA;
    assign dir   = qIdx[1:0];

    always_comb begin
        edgeHit = 1'b0;
        unique case (dir)
            2'd0: edgeHit = (cur.col == LAST_COL);
            2'd1: edgeHit = (cur.col == 5'd0);
            2'd2: edgeHit = (cur.row == LAST_ROW);
            2'd3: edgeHit = (cur.row == 4'd0);
        endcase
    end

    assign masked = cur.off || !(cur.alignedX && cur.alignedY) || edgeHit;
    assign base   = ({4'd0, cur.row} * COLS8) + {3'd0, cur.col};

    always_comb begin
        nbrAddr = base;
        unique case (dir)
            2'd0: nbrAddr = base + 8'd1;
            2'd1: nbrAddr = base - 8'd1;
            2'd2: nbrAddr = base + COLS8;
            2'd3: nbrAddr = base - COLS8;
        endcase
    end

    assign qAddr = masked ? 8'd0 : nbrAddr;

    // Address is presented during ADDR so the map's registered read
    // returns the bit during the following DATA cycle.
    assign map_rd_addr = (state == ADDR) ? qAddr : 8'd0;

    always_comb begin
        shadowNext       = shadow;
        shadowNext[qIdx] = map_rd_data & ~masked;
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state                  <= IDLE;
            qIdx                   <= 3'd0;
            shadow                 <= 8'd0;
            snapXa                 <= 11'd0;
            snapYa                 <= 11'd0;
            snapXb                 <= 11'd0;
            snapYb                 <= 11'd0;
            free_direction_alien_a <= 4'd0;
            free_direction_alien_b <= 4'd0;
            scan_done              <= 1'b0;
            busy                   <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (startOfFrame) begin
                        snapXa <= alien_top_leftX_a;
                        snapYa <= alien_top_leftY_a;
                        snapXb <= alien_top_leftX_b;
                        snapYb <= alien_top_leftY_b;
                        qIdx   <= 3'd0;
                        shadow <= 8'd0;
                        busy   <= 1'b1;
                        state  <= ADDR;
                    end
                end
                ADDR: state <= DATA;
                DATA: begin
                    shadow <= shadowNext;
                    if (qIdx == 3'd7) begin
                        free_direction_alien_a <=
                            shadowNext[3:0] | forcedBits(cellA);
                        free_direction_alien_b <=
                            shadowNext[7:4] | forcedBits(cellB);
                        scan_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        qIdx  <= qIdx + 3'd1;
                        state <= ADDR;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alien_path_scanner.sv
// Self-checking bench for alien_path_scanner: table vectors, hand-written
// timing sequences and randomized scans against a cell-geometry model.
module tb_alien_path_scanner;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic [10:0] xA = '0, yA = '0, xB = '0, yB = '0;
    logic [7:0]  mapRdAddr;
    logic        mapRdData = 1'b0;
    logic [3:0]  freeA, freeB;
    logic        scanDone, busyO;

    logic        mapMem [256];
    logic [7:0]  addrLog [8];

    int nVec = 0;
    int nMiss = 0;

    alien_path_scanner dut (
        .clk                   (clk),
        .resetN                (resetN),
        .startOfFrame          (startOfFrame),
        .alien_top_leftX_a     (xA),
        .alien_top_leftY_a     (yA),
        .alien_top_leftX_b     (xB),
        .alien_top_leftY_b     (yB),
        .map_rd_addr           (mapRdAddr),
        .map_rd_data           (mapRdData),
        .free_direction_alien_a(freeA),
        .free_direction_alien_b(freeB),
        .scan_done             (scanDone),
        .busy                  (busyO)
    );

    always #5 clk = ~clk;

    // Tunnel map RAM: registered read, data one cycle after address.
    always @(posedge clk) mapRdData <= mapMem[mapRdAddr];

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMiss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic setMap(input int mode);
        for (int i = 0; i < 256; i++) begin
            if (mode == 0) mapMem[i] = 1'b1;
            else if (mode == 2) mapMem[i] = 1'b0;
            else if (mode == 3) mapMem[i] = 1'($urandom_range(0, 1));
            else mapMem[i] = (i == 66 || i == 50);
        end
    endtask

    function automatic logic tun(input int c, input int r);
        if (c < 0 || c > 14 || r < 0 || r > 9) return 1'b0;
        return mapMem[r * 15 + c];
    endfunction

    function automatic logic [3:0] refMask(input int x, input int y);
        int dx, dy, c, r;
        logic [3:0] m;
        dx = x - 32;
        dy = y - 160;
        if (dx < 0 || dy < 0 || dx >= 480 || dy >= 320) return 4'b0000;
        c = dx / 32;
        r = dy / 32;
        if (dx % 32 != 0 && dy % 32 != 0) return 4'b0000;
        if (dx % 32 != 0) return 4'b0011;
        if (dy % 32 != 0) return 4'b1100;
        m[0] = tun(c + 1, r);
        m[1] = tun(c - 1, r);
        m[2] = tun(c, r + 1);
        m[3] = tun(c, r - 1);
        return m;
    endfunction

    // Full scan: E0 is the first posedge after startOfFrame is raised.
    task automatic runScan(input int xa, input int ya, input int xb,
                           input int yb, output logic [3:0] ga,
                           output logic [3:0] gb, output logic latOk);
        @(negedge clk);
        xA = 11'(xa); yA = 11'(ya); xB = 11'(xb); yB = 11'(yb);
        startOfFrame = 1'b1;
        @(posedge clk);
        #1 startOfFrame = 1'b0;
        latOk = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) begin
                if (!busyO || scanDone) latOk = 1'b0;
                if (k % 2 == 0) addrLog[k / 2] = mapRdAddr;
                @(posedge clk);
                #1;
            end else begin
                if (busyO || !scanDone) latOk = 1'b0;
            end
        end
        ga = freeA;
        gb = freeB;
    endtask

    typedef struct {
        int         xa, ya, xb, yb;
        int         mapMode;
        logic [3:0] expA, expB;
    } vec_t;

    vec_t       vecs [5];
    logic [3:0] ga, gb;
    logic       lat, sawDone;
    int         rx [4];

    initial begin
        vecs[0] = '{448, 160, 480, 448, 0, 4'b0111, 4'b1010};
        vecs[1] = '{192, 288,  16, 160, 1, 4'b1001, 4'b0000};
        vecs[2] = '{200, 288, 192, 300, 2, 4'b0011, 4'b1100};
        vecs[3] = '{ 16, 160,  32, 480, 0, 4'b0000, 4'b0000};
        vecs[4] = '{ 32, 160, 480, 160, 0, 4'b0101, 4'b0110};

        setMap(0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_maskA", 32'(freeA), 0);
        check("reset_maskB", 32'(freeB), 0);
        check("reset_busy", 32'(busyO), 0);
        check("reset_done", 32'(scanDone), 0);
        check("reset_addr", 32'(mapRdAddr), 0);
        resetN = 1'b1;

        for (int v = 0; v < 5; v++) begin
            setMap(vecs[v].mapMode);
            runScan(vecs[v].xa, vecs[v].ya, vecs[v].xb, vecs[v].yb,
                    ga, gb, lat);
            check($sformatf("vec%0d_maskA", v), 32'(ga), 32'(vecs[v].expA));
            check($sformatf("vec%0d_maskB", v), 32'(gb), 32'(vecs[v].expB));
            check($sformatf("vec%0d_latency", v), 32'(lat), 1);
            if (v == 1) begin
                check("addr_q0", 32'(addrLog[0]), 66);
                check("addr_q1", 32'(addrLog[1]), 64);
                check("addr_q2", 32'(addrLog[2]), 80);
                check("addr_q3", 32'(addrLog[3]), 50);
            end
        end

        // Reset at E5 aborts the scan and clears the published masks.
        setMap(0);
        runScan(448, 160, 480, 448, ga, gb, lat);
        @(negedge clk);
        startOfFrame = 1'b1;
        @(posedge clk);
        #1 startOfFrame = 1'b0;
        repeat (4) @(posedge clk);
        #1 resetN = 1'b0;
        @(posedge clk);
        #1;
        check("abort_maskA", 32'(freeA), 0);
        check("abort_maskB", 32'(freeB), 0);
        check("abort_busy", 32'(busyO), 0);
        resetN = 1'b1;
        sawDone = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clk);
            #1 if (scanDone) sawDone = 1'b1;
        end
        check("abort_no_done", 32'(sawDone), 0);

        // Snapshot hold, ignored mid-scan trigger, back-to-back restart.
        setMap(1);
        @(negedge clk);
        xA = 11'd192; yA = 11'd288; xB = 11'd16; yB = 11'd160;
        startOfFrame = 1'b1;
        @(posedge clk);
        #1 startOfFrame = 1'b0;
        lat = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
            if (k == 3) xA = 11'd448;
            if (k == 7) startOfFrame = 1'b1;
            if (k == 8) startOfFrame = 1'b0;
            if (k < 16 && (scanDone || !busyO)) lat = 1'b0;
        end
        check("snap_done", 32'(scanDone), 1);
        check("snap_timing", 32'(lat), 1);
        check("snap_maskA", 32'(freeA), 32'(4'b1001));
        startOfFrame = 1'b1;
        @(posedge clk);
        #1 startOfFrame = 1'b0;
        check("restart_busy", 32'(busyO), 1);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk);
            #1;
        end
        check("restart_done", 32'(scanDone), 1);
        check("restart_maskA", 32'(freeA), 32'(refMask(448, 288)));

        // Randomized positions, biased towards cell-aligned coordinates.
        for (int t = 0; t < 40; t++) begin
            setMap(3);
            for (int j = 0; j < 4; j++) begin
                rx[j] = 32 * int'($urandom_range(0, 17));
                if ($urandom_range(0, 3) == 0) rx[j] += int'($urandom_range(1, 31));
            end
            rx[1] += 128;
            rx[3] += 128;
            runScan(rx[0], rx[1], rx[2], rx[3], ga, gb, lat);
            check($sformatf("rnd%0d_maskA", t), 32'(ga),
                  32'(refMask(rx[0], rx[1])));
            check($sformatf("rnd%0d_maskB", t), 32'(gb),
                  32'(refMask(rx[2], rx[3])));
            check($sformatf("rnd%0d_latency", t), 32'(lat), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
